// File: rtl/alu_seq.sv
// Registered ALU with Z/N/C/V flags, valid/ready handshake and an iterative
// shift-add unsigned multiplier (WIDTH cycles) behind a two-state FSM.
module alu_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SHW    = $clog2(WIDTH),
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0011;
  localparam logic [3:0] OpOr  = 4'b0100;
  localparam logic [3:0] OpXor = 4'b0101;
  localparam logic [3:0] OpNot = 4'b0110;
  localparam logic [3:0] OpClr = 4'b0111;
  localparam logic [3:0] OpShl = 4'b1000;
  localparam logic [3:0] OpShr = 4'b1001;
  localparam logic [3:0] OpAsr = 4'b1010;
  localparam logic [3:0] OpMul = 4'b1011;

  localparam logic [WIDTH-1:0] CntInit = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] CntLast = WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               ov_q, ov_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     ext;
  logic [SHW-1:0]     sh_amt;
  logic [2*WIDTH-1:0] acc_next;
  logic               accept;
  logic               is_mul;

  assign sh_amt = num2[SHW-1:0];
  assign accept = in_valid & in_ready;
  assign is_mul = (MUL_EN != 0) && (opcode == OpMul);

  // Single-cycle datapath; ext carries the extra bit used for carry/borrow/shift-out.
  always_comb begin
    alu_res = num1;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    ext     = '0;
    case (opcode)
      OpAdd: begin
        ext     = {1'b0, num1} + {1'b0, num2};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (num1[WIDTH-1] == num2[WIDTH-1]) && (ext[WIDTH-1] != num1[WIDTH-1]);
      end
      OpSub: begin
        ext     = {1'b0, num1} - {1'b0, num2};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (num1[WIDTH-1] != num2[WIDTH-1]) && (ext[WIDTH-1] != num1[WIDTH-1]);
      end
      OpAnd: alu_res = num1 & num2;
      OpOr:  alu_res = num1 | num2;
      OpXor: alu_res = num1 ^ num2;
      OpNot: alu_res = ~num1;
      OpClr: alu_res = '0;
      OpShl: begin
        ext     = {1'b0, num1} << sh_amt;
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OpShr: begin
        ext     = {num1, 1'b0} >> sh_amt;
        alu_res = ext[WIDTH:1];
        alu_c   = ext[0];
      end
      OpAsr: begin
        ext     = $unsigned($signed({num1, 1'b0}) >>> sh_amt);
        alu_res = ext[WIDTH:1];
        alu_c   = ext[0];
      end
      default: alu_res = num1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    ov_d     = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, num1};
            mplier_d = num2;
            cnt_d    = CntInit;
          end else begin
            res_d   = alu_res;
            hi_d    = '0;
            flags_d = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
            ov_d    = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntLast;
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          res_d   = acc_next[WIDTH-1:0];
          hi_d    = acc_next[2*WIDTH-1:WIDTH];
          flags_d = {acc_next[WIDTH-1:0] == '0, acc_next[WIDTH-1],
                     acc_next[2*WIDTH-1:WIDTH] != '0, 1'b0};
          ov_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      res_q    <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      ov_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      ov_q     <= ov_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = ov_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: hand-derived vector table, directed MUL/reset sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  num1;
  logic [W-1:0]  num2;
  logic [3:0]    opcode;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic [3:0]    flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num1     (num1),
    .num2     (num2),
    .opcode   (opcode),
    .out_valid(out_valid),
    .result   (result),
    .result_hi(result_hi),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [3:0]   f;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    opcode   = op;
    num1     = a;
    num2     = b;
  endtask

  // Reference model from the operation definitions using wide integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic [3:0] f);
    longint ua, ub, sa, sb, t, st, rr, hh;
    int     s;
    bit     c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - 65536 : ua;
    sb = b[W-1] ? ub - 65536 : ub;
    s  = int'(b[3:0]);
    c  = 0;
    v  = 0;
    hh = 0;
    case (op)
      4'h1: begin
        t  = ua + ub;
        rr = t & 'hFFFF;
        c  = t > 65535;
        st = sa + sb;
        v  = (st > 32767) || (st < -32768);
      end
      4'h2: begin
        t  = ua - ub;
        rr = t & 'hFFFF;
        c  = ua < ub;
        st = sa - sb;
        v  = (st > 32767) || (st < -32768);
      end
      4'h3: rr = ua & ub;
      4'h4: rr = ua | ub;
      4'h5: rr = ua ^ ub;
      4'h6: rr = 65535 - ua;
      4'h7: rr = 0;
      4'h8: begin
        rr = (ua << s) & 'hFFFF;
        c  = (s != 0) && (((ua >> (16 - s)) & 1) != 0);
      end
      4'h9: begin
        rr = ua >> s;
        c  = (s != 0) && (((ua >> (s - 1)) & 1) != 0);
      end
      4'hA: begin
        rr = (sa >>> s) & 'hFFFF;
        c  = (s != 0) && (((sa >>> (s - 1)) & 1) != 0);
      end
      4'hB: begin
        t  = ua * ub;
        rr = t & 'hFFFF;
        hh = t >> 16;
        c  = hh != 0;
      end
      default: rr = ua;
    endcase
    r = rr[W-1:0];
    h = hh[W-1:0];
    f = {rr == 0, rr >= 32768, c, v};
  endtask

  initial begin
    logic [W-1:0] er, eh;
    logic [3:0]   ef;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           lat;
    int           pulses;

    tbl[0]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101};
    tbl[1]  = '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0110};
    tbl[2]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010};
    tbl[3]  = '{4'h8, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0010};
    tbl[4]  = '{4'hA, 16'h8000, 16'h000F, 16'hFFFF, 16'h0000, 4'b0100};
    tbl[5]  = '{4'h9, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 4'b0000};
    tbl[6]  = '{4'h3, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0100};
    tbl[7]  = '{4'h4, 16'h0F0F, 16'h00F0, 16'h0FFF, 16'h0000, 4'b0000};
    tbl[8]  = '{4'h5, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000};
    tbl[9]  = '{4'h6, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 4'b0100};
    tbl[10] = '{4'h7, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b1000};
    tbl[11] = '{4'hF, 16'h8765, 16'h1111, 16'h8765, 16'h0000, 4'b0100};
    tbl[12] = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001};
    tbl[13] = '{4'h9, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 4'b0010};
    tbl[14] = '{4'h0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 4'b1000};

    reset    = 1'b1;
    in_valid = 1'b0;
    opcode   = 4'h0;
    num1     = '0;
    num2     = '0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_hi", 32'(result_hi), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    tick();

    // Table applied back-to-back, one op per cycle.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_hi", i), 32'(result_hi), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].f));
    end
    in_valid = 1'b0;
    tick();
    chk("idle_no_valid", 32'(out_valid), 32'd0);
    chk("idle_hold", 32'(result), 32'(tbl[14].r));

    // Directed MUL with ADDs offered while busy.
    drive(4'hB, 16'h1234, 16'h0100);
    tick();
    chk("mul_ready_low", 32'(in_ready), 32'd0);
    chk("mul_no_early", 32'(out_valid), 32'd0);
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      drive(4'h1, 16'h0001, 16'h0001);
      tick();
      if (out_valid) begin
        lat = j;
        break;
      end
      if (in_ready) begin
        chk("mul_busy_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("mul_latency", 32'(lat), 32'd16);
    chk("mul_result", 32'(result), 32'h3400);
    chk("mul_hi", 32'(result_hi), 32'h0012);
    chk("mul_flags", 32'(flags), 32'b0010);
    chk("mul_done_ready", 32'(in_ready), 32'd1);
    tick();
    chk("mul_single_pulse", 32'(out_valid), 32'd0);
    chk("mul_hold", 32'(result), 32'h3400);

    // Reset five cycles into a MUL.
    drive(4'hB, 16'hFFFF, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_ready", 32'(in_ready), 32'd1);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_hi", 32'(result_hi), 32'd0);
    chk("mrst_flags", 32'(flags), 32'd0);
    tick();
    reset = 1'b0;
    drive(4'h1, 16'h0002, 16'h0003);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", 32'(result), 32'd5);
    chk("post_rst_hi", 32'(result_hi), 32'd0);
    chk("post_rst_flags", 32'(flags), 32'd0);
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("no_stale_mul", 32'(pulses), 32'd0);
    chk("no_stale_result", 32'(result), 32'd5);

    // Randomized ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
      model(op, a, b, er, eh, ef);
      drive(op, a, b);
      tick();
      in_valid = 1'b0;
      if (op == 4'hB) begin
        chk($sformatf("rnd%0d_busy", i), 32'(in_ready), 32'd0);
        lat = 0;
        for (int j = 1; j <= 30; j++) begin
          tick();
          if (out_valid) begin
            lat = j;
            break;
          end
        end
        chk($sformatf("rnd%0d_mul_lat", i), 32'(lat), 32'd16);
      end else begin
        chk($sformatf("rnd%0d_valid", i), 32'(out_valid), 32'd1);
      end
      chk($sformatf("rnd%0d_op%h_result", i, op), 32'(result), 32'(er));
      chk($sformatf("rnd%0d_op%h_hi", i, op), 32'(result_hi), 32'(eh));
      chk($sformatf("rnd%0d_op%h_flags", i, op), 32'(flags), 32'(ef));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk($sformatf("rnd%0d_gap_valid", i), 32'(out_valid), 32'd0);
        chk($sformatf("rnd%0d_gap_hold", i), 32'(result), 32'(er));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
